// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencing controller.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_BW = 128;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARK0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequences one AES-128 encryption: owns the state register, pulses the key
// generator and feeds the combinational round function round by round.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int BW = AES_BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_key,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  input  logic          abort,
  output logic [BW-1:0] ke_key,
  output logic          ke_restart,
  output logic          ke_step,
  input  logic [BW-1:0] ke_round_key,
  output logic [BW-1:0] rf_state,
  output logic [BW-1:0] rf_key,
  output logic          rf_final,
  input  logic [BW-1:0] rf_result,
  output logic          busy,
  output logic [31:0]   blk_count
);

  localparam logic [3:0] LP_NR = 4'(NR);

  aes_ctrl_state_e r_state;
  logic [BW-1:0]   r_data;
  logic [BW-1:0]   r_key;
  logic [3:0]      r_rnd;
  logic            r_restart;
  logic            r_step;
  logic [31:0]     r_cnt;

  logic            w_idle;

  assign w_idle     = (r_state == IDLE);
  assign in_ready   = rst_n & w_idle;
  assign busy       = ~w_idle;
  assign out_valid  = (r_state == DONE);
  assign out_data   = r_data;
  assign ke_key     = r_key;
  assign ke_restart = r_restart;
  assign ke_step    = r_step;
  assign rf_state   = r_data;
  assign rf_key     = ke_round_key;
  assign rf_final   = (r_state == ROUND) && (r_rnd == LP_NR);
  assign blk_count  = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_key     <= '0;
      r_rnd     <= '0;
      r_restart <= 1'b0;
      r_step    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_restart <= 1'b0;
      r_step    <= 1'b0;
      // Abort wins over every in-flight action, including the output handshake.
      if (abort && !w_idle) begin
        r_state   <= IDLE;
        r_restart <= 1'b1;
        r_rnd     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid) begin
              r_key     <= in_key;
              r_data    <= in_data;
              r_restart <= 1'b1;
              r_state   <= ARK0;
            end
          end
          ARK0: begin
            // Key generator presents K0 during the restart pulse cycle.
            r_data  <= r_data ^ ke_round_key;
            r_step  <= 1'b1;
            r_rnd   <= 4'd1;
            r_state <= ROUND;
          end
          ROUND: begin
            r_data <= rf_result;
            if (r_rnd == LP_NR) begin
              r_state <= DONE;
            end else begin
              r_step <= 1'b1;
              r_rnd  <= r_rnd + 4'd1;
            end
          end
          DONE: begin
            if (out_ready) begin
              r_cnt   <= r_cnt + 32'd1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// End-to-end bench: controller plus behavioural key generator and round
// function, checked against FIPS-197 vectors and a whole-cipher reference.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         abort;
  logic [127:0] ke_key;
  logic         ke_restart;
  logic         ke_step;
  logic [127:0] ke_round_key;
  logic [127:0] rf_state;
  logic [127:0] rf_key;
  logic         rf_final;
  logic [127:0] rf_result;
  logic         busy;
  logic [31:0]  blk_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10), .BW(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .abort(abort),
    .ke_key(ke_key), .ke_restart(ke_restart), .ke_step(ke_step), .ke_round_key(ke_round_key),
    .rf_state(rf_state), .rf_key(rf_key), .rf_final(rf_final), .rf_result(rf_result),
    .busy(busy), .blk_count(blk_count)
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p = x;
    logic [7:0] r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    if (x == 8'h00) r = 8'h00;
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = k[127:96] ^ t;
    w1  = k[95:64] ^ w0;
    w2  = k[63:32] ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int r = 0; r < 4; r++) u[4*c + r] = t[4*c + r];
      end else begin
        u[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        u[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        u[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
        u[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = u[i];
    return o ^ k;
  endfunction

  // Whole-cipher reference: initial AddRoundKey then 10 rounds, last without MixColumns.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    logic [7:0]   rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k  = next_key(k, rc);
      rc = xt(rc);
      s  = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // ---------------- neighbouring datapath blocks ----------------
  logic [127:0] kg_k;
  logic [7:0]   kg_rc;

  always_comb begin
    ke_round_key = kg_k;
    if (ke_restart)   ke_round_key = ke_key;
    else if (ke_step) ke_round_key = next_key(kg_k, kg_rc);
  end

  always @(posedge clk) begin
    kg_k <= ke_round_key;
    if (ke_restart)   kg_rc <= 8'h01;
    else if (ke_step) kg_rc <= xt(kg_rc);
  end

  assign rf_result = aes_round(rf_state, rf_key, rf_final);

  // ---------------- event monitor ----------------
  int cyc = 0, n_step = 0, n_rst = 0, n_acc = 0, n_hs = 0, n_badstep = 0;
  int acc_cyc = 0, hs_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ke_step)    n_step <= n_step + 1;
    if (ke_restart) n_rst  <= n_rst + 1;
    if (in_valid && in_ready) begin n_acc <= n_acc + 1; acc_cyc <= cyc; end
    if (out_valid && out_ready) begin n_hs <= n_hs + 1; hs_cyc <= cyc; end
    if (ke_step && (!busy || out_valid)) n_badstep <= n_badstep + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      step1();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step1();
    out_ready = 1'b0;
  endtask

  task automatic do_block(input string tag, input logic [127:0] k, input logic [127:0] pt,
                          input logic [127:0] exp, input int hold);
    int s0, r0, lat;
    logic [31:0] bc0;
    chk({tag, "_ready"}, 128'(in_ready), 128'(1));
    s0 = n_step; r0 = n_rst; bc0 = blk_count;
    in_key = k; in_data = pt; in_valid = 1'b1;
    step1();
    in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_lat"}, 128'(lat), 128'(11));
    chk({tag, "_steps"}, 128'(n_step - s0), 128'(10));
    chk({tag, "_restarts"}, 128'(n_rst - r0), 128'(1));
    chk({tag, "_ct"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      step1();
      chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_cnt"}, 128'(blk_count), 128'(bc0));
    end
    chk({tag, "_hold_steps"}, 128'(n_step - s0), 128'(10));
    handshake();
    chk({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    chk({tag, "_cnt"}, 128'(blk_count), 128'(bc0 + 32'd1));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] rk, rp, d1, d2;
    int lat, a0, h1, bc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    in_key = '0; in_data = '0;
    step1(); step1();

    // Reset state
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_cnt", 128'(blk_count), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_pulses", 128'({ke_restart, ke_step}), 128'(0));
    rst_n = 1'b1;
    step1();

    // 1: FIPS-197 C.1
    do_block("c1", C1_KEY, C1_PT, C1_CT, 0);
    chk("c1_blk", 128'(blk_count), 128'(1));

    // 2: back-to-back with in_valid held high
    a0 = n_acc;
    in_key = C1_KEY; in_data = C1_PT; in_valid = 1'b1; out_ready = 1'b1;
    step1();
    wait_valid(lat);
    d1 = out_data;
    step1();
    h1 = hs_cyc;
    in_key = B_KEY; in_data = B_PT;
    step1();
    chk("b2b_acc_cycle", 128'(acc_cyc), 128'(h1 + 1));
    wait_valid(lat);
    d2 = out_data;
    in_valid = 1'b0;
    step1();
    out_ready = 1'b0;
    chk("b2b_ct1", d1, C1_CT);
    chk("b2b_ct2", d2, B_CT);
    chk("b2b_accepts", 128'(n_acc - a0), 128'(2));
    chk("b2b_cnt", 128'(blk_count), 128'(3));

    // 3: backpressure on a random block
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    do_block("bp", rk, rp, aes_ref(rk, rp), 7);

    // 4: abort at rnd = 5
    bc = blk_count;
    rk = {$urandom, $urandom, $urandom, $urandom};
    in_key = rk; in_data = rp; in_valid = 1'b1;
    step1();
    in_valid = 1'b0;
    repeat (5) step1();
    abort = 1'b1;
    step1();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(out_valid), 128'(0));
    chk("abort_restart", 128'(ke_restart), 128'(1));
    chk("abort_cnt", 128'(blk_count), 128'(bc));
    step1();
    do_block("abort_next", C1_KEY, C1_PT, C1_CT, 0);

    // 5: reset pulse at rnd = 3
    in_key = B_KEY; in_data = B_PT; in_valid = 1'b1;
    step1();
    in_valid = 1'b0;
    repeat (3) step1();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_low", 128'(in_ready), 128'(0));
    step1();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_cnt", 128'(blk_count), 128'(0));
    chk("midrst_ready", 128'(in_ready), 128'(1));
    chk("midrst_pulses", 128'({ke_restart, ke_step, out_valid}), 128'(0));
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    do_block("midrst_next", rk, rp, aes_ref(rk, rp), 2);

    // 6a: in_valid toggling while busy is ignored
    a0 = n_acc;
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    in_key = rk; in_data = rp; in_valid = 1'b1;
    step1();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_key = {$urandom, $urandom, $urandom, $urandom};
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step1();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    chk("toggle_ct", out_data, aes_ref(rk, rp));
    chk("toggle_accepts", 128'(n_acc - a0), 128'(1));
    handshake();

    // 6b: abort in IDLE does not block an accept
    a0 = n_acc;
    abort = 1'b1; in_key = B_KEY; in_data = B_PT; in_valid = 1'b1;
    step1();
    abort = 1'b0; in_valid = 1'b0;
    chk("idle_abort_busy", 128'(busy), 128'(1));
    chk("idle_abort_acc", 128'(n_acc - a0), 128'(1));
    wait_valid(lat);
    chk("idle_abort_ct", out_data, B_CT);
    handshake();
    chk("no_bad_steps", 128'(n_badstep), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
